// File: rtl/vx_fetch_warp_arbiter_pkg.sv
// vx_fetch_warp_arbiter_pkg: shared fetch-request type, sizing and round-robin helper.
package vx_fetch_warp_arbiter_pkg;
   localparam int NUM_WARPS   = 4;
   localparam int NUM_THREADS = 4;
   localparam int PC_BITS     = 31;
   localparam int UUID_WIDTH  = 44;
   localparam int MAX_PENDING = 2;
   localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int CNT_WIDTH   = $clog2(MAX_PENDING + 1);

   typedef struct packed {
      logic [UUID_WIDTH-1:0]  uuid;
      logic [NW_WIDTH-1:0]    wid;
      logic [NUM_THREADS-1:0] tmask;
      logic [PC_BITS-1:0]     PC;
   } fetch_req_t;

   // First set bit of elig scanning upward from ptr+1 with wrap; the reverse loop lets the nearest hit win.
   function automatic logic [NW_WIDTH-1:0] rr_pick(input logic [NUM_WARPS-1:0] elig, input logic [NW_WIDTH-1:0] ptr);
      int idx;
      rr_pick = ptr;
      for (int k = NUM_WARPS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_WARPS;
         if (elig[idx]) rr_pick = NW_WIDTH'(idx);
      end
   endfunction
endpackage

// File: rtl/vx_fetch_warp_arbiter_if.sv
// vx_fetch_warp_arbiter_if: valid/ready schedule channel from the warp arbiter to the fetch stage.
interface vx_fetch_warp_arbiter_if;
   import vx_fetch_warp_arbiter_pkg::*;
   logic       valid;
   logic       ready;
   fetch_req_t data;
   modport master (output valid, data, input ready);
   modport slave  (input valid, data, output ready);
endinterface

// File: rtl/vx_fetch_warp_arbiter_credit_ctr.sv
// vx_fetch_warp_arbiter_credit_ctr: per-warp in-flight fetch counter with full flag and underflow guard.
module vx_fetch_warp_arbiter_credit_ctr
   import vx_fetch_warp_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_incr,
   input  logic i_decr,
   output logic o_full,
   output logic o_nonzero
);
   logic [CNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_count <= '0;
      else if (i_incr & ~i_decr) r_count <= r_count + CNT_WIDTH'(1);
      else if (i_decr & ~i_incr & (r_count != '0)) r_count <= r_count - CNT_WIDTH'(1);
   end

   assign o_full    = r_count == CNT_WIDTH'(MAX_PENDING);
   assign o_nonzero = |r_count;

   a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(i_decr && !i_incr && r_count == '0))
      else $warning("retire on warp with no outstanding fetch");
endmodule

// File: rtl/vx_fetch_warp_arbiter.sv
// vx_fetch_warp_arbiter: round-robin warp selection into a single-entry schedule register,
// credit-limited per warp, generating sequential uuids for fetched instructions.
module vx_fetch_warp_arbiter
   import vx_fetch_warp_arbiter_pkg::*;
(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_WARPS-1:0]             i_warp_valid,
   input  logic [NUM_WARPS-1:0]             i_warp_stall,
   input  logic [NUM_WARPS*PC_BITS-1:0]     i_warp_PC,
   input  logic [NUM_WARPS*NUM_THREADS-1:0] i_warp_tmask,
   output logic [NUM_WARPS-1:0]             o_warp_grant,
   vx_fetch_warp_arbiter_if.master          sched_if,
   input  logic                             i_retire_valid,
   input  logic [NW_WIDTH-1:0]              i_retire_wid,
   output logic [NUM_WARPS-1:0]             o_pending_full,
   output logic                             o_busy
);
   logic                  r_valid;
   fetch_req_t            r_req;
   logic [NW_WIDTH-1:0]   r_rr_ptr;
   logic [UUID_WIDTH-1:0] r_uuid;

   logic                  w_load_en;
   logic [NUM_WARPS-1:0]  w_eligible;
   logic [NUM_WARPS-1:0]  w_nonzero;
   logic [NW_WIDTH-1:0]   w_sel;
   logic                  w_fire;

   assign w_load_en  = ~r_valid | sched_if.ready;
   assign w_eligible = i_warp_valid & ~i_warp_stall & ~o_pending_full;
   assign w_sel      = rr_pick(w_eligible, r_rr_ptr);
   // Gated by reset so no grant leaks out while the schedule register is held clear.
   assign w_fire     = w_load_en & (|w_eligible) & ~reset;

   assign o_warp_grant = w_fire ? (NUM_WARPS'(1) << w_sel) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_req    <= '0;
         r_rr_ptr <= NW_WIDTH'(NUM_WARPS - 1);
         r_uuid   <= '0;
      end else if (w_load_en) begin
         r_valid <= w_fire;
         if (w_fire) begin
            r_req.uuid  <= r_uuid;
            r_req.wid   <= w_sel;
            r_req.tmask <= i_warp_tmask[int'(w_sel)*NUM_THREADS +: NUM_THREADS];
            r_req.PC    <= i_warp_PC[int'(w_sel)*PC_BITS +: PC_BITS];
            r_rr_ptr    <= w_sel;
            r_uuid      <= r_uuid + UUID_WIDTH'(1);
         end
      end
   end

   assign sched_if.valid = r_valid;
   assign sched_if.data  = r_req;

   for (genvar i = 0; i < NUM_WARPS; i++) begin : g_ctr
      vx_fetch_warp_arbiter_credit_ctr u_ctr (
         .clk       (clk),
         .reset     (reset),
         .i_incr    (o_warp_grant[i]),
         .i_decr    (i_retire_valid & (i_retire_wid == NW_WIDTH'(i))),
         .o_full    (o_pending_full[i]),
         .o_nonzero (w_nonzero[i])
      );
   end

   assign o_busy = r_valid | (|w_nonzero);

   a_pc_nonzero: assert property (@(posedge clk) disable iff (reset) r_valid |-> (r_req.PC != '0));
   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(o_warp_grant));
   a_retire_wid: assert property (@(posedge clk) disable iff (reset) i_retire_valid |-> (int'(i_retire_wid) < NUM_WARPS));
endmodule

// File: tb/tb_vx_fetch_warp_arbiter.sv
// tb_vx_fetch_warp_arbiter: directed checks of arbitration order, backpressure, credits, stalls and uuid wrap.
module tb_vx_fetch_warp_arbiter;
   import vx_fetch_warp_arbiter_pkg::*;

   logic                             clk = 1'b0;
   logic                             reset;
   logic [NUM_WARPS-1:0]             warp_valid, warp_stall, grant, full;
   logic [NUM_WARPS*PC_BITS-1:0]     warp_pc;
   logic [NUM_WARPS*NUM_THREADS-1:0] warp_tmask;
   logic                             retire_valid, busy;
   logic [NW_WIDTH-1:0]              retire_wid;
   int                               n_cmp = 0;
   int                               n_err = 0;

   vx_fetch_warp_arbiter_if sched_if();

   vx_fetch_warp_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_warp_valid   (warp_valid),
      .i_warp_stall   (warp_stall),
      .i_warp_PC      (warp_pc),
      .i_warp_tmask   (warp_tmask),
      .o_warp_grant   (grant),
      .sched_if       (sched_if),
      .i_retire_valid (retire_valid),
      .i_retire_wid   (retire_wid),
      .o_pending_full (full),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      warp_valid = '0; warp_stall = '0; retire_valid = 1'b0; retire_wid = '0; sched_if.ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [63:0] pc_of(input int w);
      return 64'(32'h100 + w * 16);
   endfunction

   function automatic logic [63:0] tm_of(input int w);
      return 64'((1 << (w + 1)) - 1);
   endfunction

   task automatic expect_req(input string tag, input int wid, input int uuid);
      check({tag, "_valid"}, 64'(sched_if.valid), 64'd1);
      check({tag, "_wid"}, 64'(sched_if.data.wid), 64'(wid));
      check({tag, "_uuid"}, 64'(sched_if.data.uuid), 64'(uuid));
      check({tag, "_pc"}, 64'(sched_if.data.PC), pc_of(wid));
      check({tag, "_tmask"}, 64'(sched_if.data.tmask), tm_of(wid));
   endtask

   initial begin
      int seq5[6];
      seq5 = '{1, 3, 1, 3, 0, 2};
      for (int i = 0; i < NUM_WARPS; i++) begin
         warp_pc[i*PC_BITS +: PC_BITS]             = PC_BITS'(pc_of(i));
         warp_tmask[i*NUM_THREADS +: NUM_THREADS]  = NUM_THREADS'(tm_of(i));
      end
      warp_valid = '0; warp_stall = '0; retire_valid = 1'b0; retire_wid = '0; sched_if.ready = 1'b1;
      reset = 1'b1;
      tick(); tick();
      check("rst_valid", 64'(sched_if.valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      reset = 1'b0;

      // round-robin from warp 0 with uuids 0..4
      warp_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1 check("t1_grant", 64'(grant), 64'(1) << (k % 4));
         tick();
         expect_req("t1", k % 4, k);
      end
      warp_valid = '0;
      #1 check("t1_full", 64'(full), 64'h1);
      check("t1_busy", 64'(busy), 64'd1);
      warp_valid = 4'hF;
      #2 reset = 1'b1;
      #1 check("t1_rst_valid", 64'(sched_if.valid), 64'd0);
      check("t1_rst_grant", 64'(grant), 64'd0);
      check("t1_rst_full", 64'(full), 64'd0);
      check("t1_rst_busy", 64'(busy), 64'd0);
      check("t1_rst_uuid", 64'(sched_if.data.uuid), 64'd0);

      // backpressure holding warp 2
      do_reset();
      warp_valid = 4'hF;
      repeat (3) tick();
      sched_if.ready = 1'b0;
      warp_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         #1 check("t2_hold_grant", 64'(grant), 64'd0);
         tick();
         expect_req("t2_hold", 2, 2);
      end
      warp_valid = 4'hF;
      sched_if.ready = 1'b1;
      #1 check("t2_grant", 64'(grant), 64'b1000);
      tick();
      expect_req("t2_next", 3, 3);

      // credit limit on warp 1
      do_reset();
      warp_valid = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         #1 check("t3_grant", 64'(grant), 64'b0010);
         tick();
         expect_req("t3", 1, k);
      end
      #1 check("t3_full_grant", 64'(grant), 64'd0);
      check("t3_full", 64'(full), 64'b0010);
      tick();
      check("t3_drop_valid", 64'(sched_if.valid), 64'd0);
      retire_valid = 1'b1; retire_wid = 1;
      #1 check("t3_ret_grant", 64'(grant), 64'd0);
      tick();
      retire_valid = 1'b0;
      #1 check("t3_after_full", 64'(full), 64'd0);
      check("t3_after_grant", 64'(grant), 64'b0010);
      tick();
      expect_req("t3_after", 1, 2);
      check("t3_refull", 64'(full), 64'b0010);

      // grant and retire together on warp 0 at count 1
      do_reset();
      warp_valid = 4'b0001;
      tick();
      retire_valid = 1'b1; retire_wid = 0;
      #1 check("t4_grant", 64'(grant), 64'b0001);
      tick();
      retire_valid = 1'b0;
      #1 check("t4_full", 64'(full), 64'd0);
      check("t4_grant2", 64'(grant), 64'b0001);
      tick();
      check("t4_full2", 64'(full), 64'b0001);
      expect_req("t4", 0, 2);

      // stalled warps skipped, then rotation resumes after last grant
      do_reset();
      warp_valid = 4'hF; warp_stall = 4'b0101;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) warp_stall = '0;
         #1 check("t5_grant", 64'(grant), 64'(1) << seq5[k]);
         tick();
         expect_req("t5", seq5[k], k);
      end
      check("t5_full", 64'(full), 64'b1010);

      // uuid wrap and spurious retire
      do_reset();
      force dut.r_uuid = {UUID_WIDTH{1'b1}};
      #1 release dut.r_uuid;
      warp_valid = 4'b0001;
      #1 check("t6_grant", 64'(grant), 64'b0001);
      tick();
      check("t6_uuid_max", 64'(sched_if.data.uuid), 64'((65'd1 << UUID_WIDTH) - 1));
      tick();
      check("t6_uuid_wrap", 64'(sched_if.data.uuid), 64'd0);
      warp_valid = '0;
      retire_valid = 1'b1; retire_wid = 2;
      tick();
      retire_valid = 1'b0;
      warp_valid = 4'b0100;
      for (int k = 0; k < 2; k++) begin
         #1 check("t6_w2_grant", 64'(grant), 64'b0100);
         tick();
      end
      check("t6_full", 64'(full), 64'b0101);
      #1 check("t6_no_grant", 64'(grant), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
